// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage: MEM/WB register, load extract, writeback mux, x0 guard.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter output.
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_reg_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [1:0]            mem_wb_sel,
  input  logic [2:0]            mem_funct3,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_load_data,
  input  logic [XLEN-1:0]       mem_pc_plus4,
  input  logic                  wb_hold,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_wdata,
  output logic                  wb_retire
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]           instret
`endif
);

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic                  r_valid;
  logic                  r_reg_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [1:0]            r_wb_sel;
  logic [2:0]            r_funct3;
  logic [XLEN-1:0]       r_alu_result;
  logic [XLEN-1:0]       r_load_data;
  logic [XLEN-1:0]       r_pc_plus4;
  logic                  r_done;

  logic [1:0]            w_offset;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_load_ext;
  logic [XLEN-1:0]       w_wdata;
  logic                  w_retire;
  logic                  w_we;

  // done marks an entry that has already written/retired, so a held entry fires only once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_reg_we     <= 1'b0;
      r_rd         <= '0;
      r_wb_sel     <= 2'b00;
      r_funct3     <= 3'b000;
      r_alu_result <= '0;
      r_load_data  <= '0;
      r_pc_plus4   <= '0;
      r_done       <= 1'b0;
    end else if (!wb_hold) begin
      r_valid      <= mem_valid;
      r_reg_we     <= mem_reg_we;
      r_rd         <= mem_rd;
      r_wb_sel     <= mem_wb_sel;
      r_funct3     <= mem_funct3;
      r_alu_result <= mem_alu_result;
      r_load_data  <= mem_load_data;
      r_pc_plus4   <= mem_pc_plus4;
      r_done       <= 1'b0;
    end else if (r_valid) begin
      r_done       <= 1'b1;
    end
  end

  assign w_offset = r_alu_result[1:0];

  always_comb begin
    w_byte = r_load_data[7:0];
    case (w_offset)
      2'd0:    w_byte = r_load_data[7:0];
      2'd1:    w_byte = r_load_data[15:8];
      2'd2:    w_byte = r_load_data[23:16];
      default: w_byte = r_load_data[31:24];
    endcase
  end

  assign w_half = w_offset[1] ? r_load_data[31:16] : r_load_data[15:0];

  always_comb begin
    w_load_ext = r_load_data;
    case (r_funct3)
      F3_LB:   w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  w_load_ext = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_ext = r_load_data;
    endcase
  end

  // wb_sel 11 falls through to the ALU result
  always_comb begin
    w_wdata = r_alu_result;
    case (r_wb_sel)
      SEL_LOAD: w_wdata = w_load_ext;
      SEL_PC4:  w_wdata = r_pc_plus4;
      default:  w_wdata = r_alu_result;
    endcase
  end

  assign w_retire = r_valid & ~r_done;
  assign w_we     = w_retire & r_reg_we & (r_rd != '0);

  assign wb_we     = w_we;
  assign wb_rd     = r_rd;
  assign wb_wdata  = w_wdata;
  assign wb_retire = w_retire;

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= 64'd0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a spec-level writeback model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_reg_we;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [31:0] mem_pc_plus4;
  logic        wb_hold;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        wb_retire;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid     (mem_valid),
    .mem_reg_we    (mem_reg_we),
    .mem_rd        (mem_rd),
    .mem_wb_sel    (mem_wb_sel),
    .mem_funct3    (mem_funct3),
    .mem_alu_result(mem_alu_result),
    .mem_load_data (mem_load_data),
    .mem_pc_plus4  (mem_pc_plus4),
    .wb_hold       (wb_hold),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_wdata      (wb_wdata),
    .wb_retire     (wb_retire)
`ifdef WB_INSTRET_EN
    ,
    .instret       (instret)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_x5    = 0;
  int n_x7    = 0;

  // Model: the instruction currently in WB and how many cycles it has sat there
  logic        m_valid, m_reg_we;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_ld, m_pc;
  int          m_age;
  longint unsigned m_instret;

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned off;
    logic [31:0] v;
    off = addr % 4;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (word >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic exp_retire();
    return m_valid && (m_age == 0);
  endfunction

  function automatic logic exp_we();
    return exp_retire() && m_reg_we && (m_rd != 5'd0);
  endfunction

  function automatic logic [31:0] exp_wdata();
    if (m_sel == 2'b01) return load_value(m_f3, m_alu, m_ld);
    if (m_sel == 2'b10) return m_pc;
    return m_alu;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag);
    check({tag, ".we"}, {63'd0, wb_we}, {63'd0, exp_we()});
    check({tag, ".retire"}, {63'd0, wb_retire}, {63'd0, exp_retire()});
    check({tag, ".rd"}, {59'd0, wb_rd}, {59'd0, m_rd});
    check({tag, ".wdata"}, {32'd0, wb_wdata}, {32'd0, exp_wdata()});
`ifdef WB_INSTRET_EN
    check({tag, ".instret"}, instret, m_instret);
`endif
    if (wb_we === 1'b1 && wb_rd == 5'd5) n_x5++;
    if (wb_we === 1'b1 && wb_rd == 5'd7) n_x7++;
  endtask

  task automatic step(input string tag);
    if (rst) begin
      m_valid = 0; m_reg_we = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
      m_alu = 0; m_ld = 0; m_pc = 0; m_age = 0; m_instret = 0;
    end else begin
      if (exp_retire()) m_instret++;
      if (!wb_hold) begin
        m_valid = mem_valid; m_reg_we = mem_reg_we; m_rd = mem_rd; m_sel = mem_wb_sel;
        m_f3 = mem_funct3; m_alu = mem_alu_result; m_ld = mem_load_data; m_pc = mem_pc_plus4;
        m_age = 0;
      end else if (m_valid) begin
        m_age++;
      end
    end
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc);
    mem_valid = v; mem_reg_we = we; mem_rd = rd; mem_wb_sel = sel; mem_funct3 = f3;
    mem_alu_result = alu; mem_load_data = ld; mem_pc_plus4 = pc;
  endtask

  initial begin
    longint unsigned ir0;
    rst = 1'b1;
    wb_hold = 1'b0;
    drive(1, 1, 5'd5, 2'b00, 3'd2, 32'h55, 32'h0, 32'h4);

    step("rst0");
    step("rst1");
    rst = 1'b0;
    check("no_x5_write", 64'(n_x5), 64'd0);

    drive(1, 1, 5'd3, 2'b00, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    step("alu");
    check("alu.wdata_const", {32'd0, wb_wdata}, 64'h0000_0000_DEAD_BEEF);

    drive(1, 1, 5'd10, 2'b01, 3'b000, 32'h1001, 32'h8077_F0A5, 32'h0);
    step("lb");
    check("lb.const", {32'd0, wb_wdata}, 64'h0000_0000_FFFF_FFF0);
    drive(1, 1, 5'd11, 2'b01, 3'b100, 32'h1003, 32'h8077_F0A5, 32'h0);
    step("lbu");
    check("lbu.const", {32'd0, wb_wdata}, 64'h0000_0000_0000_0080);
    drive(1, 1, 5'd12, 2'b01, 3'b001, 32'h1002, 32'h8077_F0A5, 32'h0);
    step("lh");
    check("lh.const", {32'd0, wb_wdata}, 64'h0000_0000_FFFF_8077);
    drive(1, 1, 5'd13, 2'b01, 3'b101, 32'h1000, 32'h8077_F0A5, 32'h0);
    step("lhu");
    check("lhu.const", {32'd0, wb_wdata}, 64'h0000_0000_0000_F0A5);
    drive(1, 1, 5'd14, 2'b01, 3'b010, 32'h1003, 32'h8077_F0A5, 32'h0);
    step("lw");
    check("lw.const", {32'd0, wb_wdata}, 64'h0000_0000_8077_F0A5);

    drive(1, 1, 5'd0, 2'b10, 3'd0, 32'h0, 32'h0, 32'h104);
    step("x0");
    check("x0.we_const", {63'd0, wb_we}, 64'd0);

    n_x7 = 0;
    drive(1, 1, 5'd7, 2'b00, 3'd0, 32'h11, 32'h0, 32'h0);
    step("hold.cap");
    wb_hold = 1'b1;
    drive(1, 1, 5'd8, 2'b11, 3'd0, 32'h22, 32'h0, 32'h0);
    step("hold1");
    step("hold2");
    step("hold3");
    wb_hold = 1'b0;
    step("hold.rel");
    check("hold.rel_rd", {59'd0, wb_rd}, 64'd8);
    check("x7_writes", 64'(n_x7), 64'd1);

    ir0 = m_instret;
    drive(1, 1, 5'd1, 2'b00, 3'd0, 32'hA1, 32'h0, 32'h0);
    step("bb1");
    drive(1, 1, 5'd2, 2'b00, 3'd0, 32'hA2, 32'h0, 32'h0);
    step("bb2");
    drive(0, 1, 5'd3, 2'b00, 3'd0, 32'hA3, 32'h0, 32'h0);
    step("bb_bubble");
    drive(1, 1, 5'd4, 2'b00, 3'd0, 32'hA4, 32'h0, 32'h0);
    step("bb4");
    drive(0, 0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0);
    step("bb_tail");
`ifdef WB_INSTRET_EN
    check("bb.instret_delta", instret - ir0, 64'd4);
`endif

    // Reset while an entry is held: it must vanish without writing
    drive(1, 1, 5'd9, 2'b00, 3'd0, 32'h99, 32'h0, 32'h0);
    step("prerst");
    wb_hold = 1'b1;
    rst = 1'b1;
    step("rst_hold");
    rst = 1'b0;
    step("rst_hold_after");
    wb_hold = 1'b0;

    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      wb_hold = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom);
      step("rand");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
